data_mem_wait_resp: RTL and testbench
=====================================

// Module: data_mem_wait_resp
// PURPOSE
// - Responder end of the CPU data-memory interface: serves mem_read/mem_write requests from the pipelined MIPS core.
// - Adds a configurable wait-state latency and drives a stall back to the pipeline.
// - Word-organised storage with alignment and range checking.
// - Sits between the core's data port and storage; replaces the zero-latency data memory when memory-latency behaviour is exercised.
// PARAMETERS
// - DEPTH_WORDS  1024  number of 32-bit words stored; must be a power of two
// - WAIT_CYCLES  2     extra cycles between request acceptance and response; 0..255
// PORTS
// - clk         in   1   system clock, rising edge
// - rst         in   1   asynchronous, active-low reset
// - adr         in   32  byte address from core
// - write_data  in   32  store data from core
// - mem_read    in   1   load request
// - mem_write   in   1   store request
// - read_data   out  32  load data, registered; valid while done=1
// - stall       out  1   hold pipeline; core keeps adr/write_data/mem_* stable while high
// - done        out  1   one-cycle pulse: access complete
// - err         out  1   one-cycle pulse with done: request rejected (no access performed)
// BEHAVIOUR
// - Reset (rst=0, asynchronous): state=IDLE, wait counter=0, read_data=0, done=0, err=0, stall=0. Memory contents are not cleared.
// - req = mem_read | mem_write.
// - Word index = adr[log2(DEPTH_WORDS)+1:2].
// - FSM states:
//   - IDLE:
//     - stall = req (combinational).
//     - On req: latch adr, write_data and op; load counter=WAIT_CYCLES.
//     - Go to WAIT if WAIT_CYCLES>0, else to RESP.
//   - WAIT:
//     - stall=1; counter decrements each cycle.
//     - When counter==1, go to RESP on the next edge.
//     - Changes on the inputs during WAIT are ignored; latched values are used.
//   - RESP:
//     - stall=0, done=1 for exactly one cycle.
//     - Always returns to IDLE; req is not sampled in RESP.
// - Access edge:
//   - The access is performed on the edge entering RESP.
//   - Write: mem[idx] <= latched write_data.
//   - Read: read_data <= mem[idx].
//   - read_data holds its value until the next read completes.
// - Latency: request visible in cycle 0 -> done in cycle WAIT_CYCLES+1; stall is high for cycles 0..WAIT_CYCLES.
// - Error conditions (checked on latched values), each of which gives: no memory write, read_data <= 0, err=1 together with done:
//   - latched adr[1:0] != 0 (misaligned);
//   - latched adr >= 4*DEPTH_WORDS (out of range);
//   - mem_read and mem_write both asserted.
// - Back-to-back: if req is still or again high in the cycle after RESP (IDLE), a new access starts with full latency. There is no pipelining of requests.
// - Reset mid-operation:
//   - An access not yet at its RESP edge is abandoned; a pending write never reaches memory.
//   - Outputs return to their reset values immediately.
// - Reset release takes effect on the next clk edge; the first request is sampled in IDLE.
// TESTING
// 1. WAIT_CYCLES=2: write 0xDEADBEEF to adr 0x10 -> stall high 3 cycles, done (err=0) in cycle 3. Then read adr 0x10 -> read_data=0xDEADBEEF with done in cycle 3.
// 2. Write 0x12345678 to misaligned adr 0x13 -> done+err pulse, stall released normally. Read 0x10 still returns 0xDEADBEEF.
// 3. Assert mem_read and mem_write together at adr 0x10 with data 0x0 -> err=1, read_data=0. Word 0x10 still 0xDEADBEEF.
// 4. Start a write of 0xCAFEF00D to 0x20 and pull rst low in the first WAIT cycle -> stall/done/err/read_data immediately 0. After release, read 0x20 returns its prior value.
// 5. WAIT_CYCLES=0 build: read request -> stall high for cycle 0 only, done in cycle 1. Out-of-range adr 0x1000 (DEPTH_WORDS=1024) -> err.
// 6. Hold mem_read high across two loads (0x10 then 0x14) -> done in cycles 3 and 7, no request dropped, and each read_data matches the stored word.

Source files
------------

// File: rtl/data_mem_wait_resp_if.sv
// rtl/data_mem_wait_resp_if.sv - core data-port bus between pipeline (master) and wait-state data memory (slave)
interface data_mem_wait_resp_if;
    logic [31:0] adr;
    logic [31:0] write_data;
    logic        mem_read;
    logic        mem_write;
    logic [31:0] read_data;
    logic        stall;
    logic        done;
    logic        err;

    modport master (
        output adr, write_data, mem_read, mem_write,
        input  read_data, stall, done, err
    );

    modport slave (
        input  adr, write_data, mem_read, mem_write,
        output read_data, stall, done, err
    );
endinterface

// File: rtl/data_mem_wait_resp.sv
// rtl/data_mem_wait_resp.sv - data memory responder with configurable wait states, stall and error reporting
module data_mem_wait_resp #(
    parameter int DEPTH_WORDS = 1024,
    parameter int WAIT_CYCLES = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    data_mem_wait_resp_if.slave  bus
);

    localparam int AW = $clog2(DEPTH_WORDS);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t      r_state;
    logic [7:0]  r_cnt;
    logic [31:0] r_adr;
    logic [31:0] r_wdata;
    logic        r_rd;
    logic        r_wr;
    logic [31:0] r_rdata;
    logic        r_done;
    logic        r_err;

    logic [31:0] r_mem [DEPTH_WORDS];

    logic          w_req;
    logic          w_fire_now;
    logic          w_fire_wait;
    logic          w_access;
    logic [31:0]   w_acc_adr;
    logic [31:0]   w_acc_wdata;
    logic          w_acc_rd;
    logic          w_acc_wr;
    logic          w_bad;
    logic [AW-1:0] w_idx;
    logic          w_mem_we;

    assign w_req = bus.mem_read | bus.mem_write;

    // With zero wait states the access happens on the accepting edge itself,
    // so the live inputs stand in for the not-yet-latched copies.
    assign w_fire_now  = (r_state == S_IDLE) && w_req && (WAIT_CYCLES == 0);
    assign w_fire_wait = (r_state == S_WAIT) && (r_cnt == 8'd1);
    assign w_access    = rst & (w_fire_now | w_fire_wait);

    assign w_acc_adr   = (r_state == S_IDLE) ? bus.adr        : r_adr;
    assign w_acc_wdata = (r_state == S_IDLE) ? bus.write_data : r_wdata;
    assign w_acc_rd    = (r_state == S_IDLE) ? bus.mem_read   : r_rd;
    assign w_acc_wr    = (r_state == S_IDLE) ? bus.mem_write  : r_wr;

    // Misaligned, beyond the stored range, or an ambiguous read+write request.
    assign w_bad = (|w_acc_adr[1:0]) | (|w_acc_adr[31:AW+2]) | (w_acc_rd & w_acc_wr);
    assign w_idx = w_acc_adr[AW+1:2];

    assign w_mem_we = w_access & w_acc_wr & ~w_bad;

    // Stall follows the request combinationally in IDLE so the core freezes in cycle 0.
    assign bus.stall     = rst & (((r_state == S_IDLE) & w_req) | (r_state == S_WAIT));
    assign bus.done      = r_done;
    assign bus.err       = r_err;
    assign bus.read_data = r_rdata;

    // Request FSM: accept, count wait states, perform access on the edge into RESP.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
            r_cnt   <= 8'd0;
            r_adr   <= 32'd0;
            r_wdata <= 32'd0;
            r_rd    <= 1'b0;
            r_wr    <= 1'b0;
            r_rdata <= 32'd0;
            r_done  <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            r_done <= 1'b0;
            r_err  <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_req) begin
                        r_adr   <= bus.adr;
                        r_wdata <= bus.write_data;
                        r_rd    <= bus.mem_read;
                        r_wr    <= bus.mem_write;
                        r_cnt   <= 8'(WAIT_CYCLES);
                        r_state <= (WAIT_CYCLES == 0) ? S_RESP : S_WAIT;
                    end
                end
                S_WAIT: begin
                    r_cnt <= r_cnt - 8'd1;
                    if (r_cnt == 8'd1) begin
                        r_state <= S_RESP;
                    end
                end
                S_RESP: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase

            if (w_access) begin
                r_done <= 1'b1;
                r_err  <= w_bad;
                if (w_bad) begin
                    r_rdata <= 32'd0;
                end else if (w_acc_rd) begin
                    r_rdata <= r_mem[w_idx];
                end
            end
        end
    end

    // Storage array: not reset, written only by a clean store on its access edge.
    always_ff @(posedge clk) begin
        if (w_mem_we) begin
            r_mem[w_idx] <= w_acc_wdata;
        end
    end

endmodule

// File: tb/tb_data_mem_wait_resp.sv
// tb/tb_data_mem_wait_resp.sv - directed testbench for data_mem_wait_resp (2 and 0 wait-state builds)
module tb_data_mem_wait_resp;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    data_mem_wait_resp_if if0 ();
    data_mem_wait_resp_if if1 ();

    data_mem_wait_resp #(.DEPTH_WORDS(1024), .WAIT_CYCLES(2)) dut0 (
        .clk (clk),
        .rst (rst),
        .bus (if0.slave)
    );

    data_mem_wait_resp #(.DEPTH_WORDS(1024), .WAIT_CYCLES(0)) dut1 (
        .clk (clk),
        .rst (rst),
        .bus (if1.slave)
    );

    int vectors = 0;
    int miscompares = 0;

    logic [15:0] obs_stall;
    logic [15:0] obs_done;
    logic [15:0] obs_err;
    logic [31:0] obs_rdata;

    task automatic set_req(input int sel, input logic rd, input logic wr,
                           input logic [31:0] a, input logic [31:0] wd);
        if (sel == 0) begin
            if0.mem_read = rd; if0.mem_write = wr; if0.adr = a; if0.write_data = wd;
        end else begin
            if1.mem_read = rd; if1.mem_write = wr; if1.adr = a; if1.write_data = wd;
        end
    endtask

    task automatic sample(input int sel, input int k);
        if (sel == 0) begin
            obs_stall[k] = if0.stall; obs_done[k] = if0.done; obs_err[k] = if0.err;
            if (if0.done === 1'b1) obs_rdata = if0.read_data;
        end else begin
            obs_stall[k] = if1.stall; obs_done[k] = if1.done; obs_err[k] = if1.err;
            if (if1.done === 1'b1) obs_rdata = if1.read_data;
        end
    endtask

    // One access: request held through RESP, dropped for the following IDLE cycle.
    task automatic run_access(input int sel, input logic rd, input logic wr,
                              input logic [31:0] a, input logic [31:0] wd);
        int w;
        w = (sel == 0) ? 2 : 0;
        obs_stall = '0; obs_done = '0; obs_err = '0; obs_rdata = 32'hXXXX_XXXX;
        @(posedge clk); #1;
        set_req(sel, rd, wr, a, wd);
        for (int k = 0; k <= w + 1; k++) begin
            if (k > 0) @(posedge clk);
            @(negedge clk);
            sample(sel, k);
        end
        @(posedge clk); #1;
        set_req(sel, 1'b0, 1'b0, a, wd);
        @(negedge clk);
        sample(sel, w + 2);
    endtask

    task automatic test_reset;
        rst = 1'b0;
        set_req(0, 1'b1, 1'b0, 32'h10, 32'h0);
        set_req(1, 1'b1, 1'b0, 32'h10, 32'h0);
        #12;
        vectors += 5;
        if (if0.stall !== 1'b0) begin miscompares++; $display("FAIL reset_stall0 got %b exp 0", if0.stall); end
        if (if1.stall !== 1'b0) begin miscompares++; $display("FAIL reset_stall1 got %b exp 0", if1.stall); end
        if (if0.done !== 1'b0) begin miscompares++; $display("FAIL reset_done got %b exp 0", if0.done); end
        if (if0.err !== 1'b0) begin miscompares++; $display("FAIL reset_err got %b exp 0", if0.err); end
        if (if0.read_data !== 32'h0) begin miscompares++; $display("FAIL reset_rdata got %h exp 0", if0.read_data); end
        set_req(0, 1'b0, 1'b0, 32'h0, 32'h0);
        set_req(1, 1'b0, 1'b0, 32'h0, 32'h0);
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic test_write_read;
        run_access(0, 1'b0, 1'b1, 32'h10, 32'hDEAD_BEEF);
        vectors += 3;
        if (obs_stall !== 16'h0007) begin miscompares++; $display("FAIL wr_stall got %h exp 0007", obs_stall); end
        if (obs_done !== 16'h0008) begin miscompares++; $display("FAIL wr_done got %h exp 0008", obs_done); end
        if (obs_err !== 16'h0000) begin miscompares++; $display("FAIL wr_err got %h exp 0000", obs_err); end
        run_access(0, 1'b1, 1'b0, 32'h10, 32'h0);
        vectors += 3;
        if (obs_stall !== 16'h0007) begin miscompares++; $display("FAIL rd_stall got %h exp 0007", obs_stall); end
        if (obs_done !== 16'h0008) begin miscompares++; $display("FAIL rd_done got %h exp 0008", obs_done); end
        if (obs_rdata !== 32'hDEAD_BEEF) begin miscompares++; $display("FAIL rd_data got %h exp deadbeef", obs_rdata); end
    endtask

    task automatic test_misaligned;
        run_access(0, 1'b0, 1'b1, 32'h13, 32'h1234_5678);
        vectors += 4;
        if (obs_stall !== 16'h0007) begin miscompares++; $display("FAIL mis_stall got %h exp 0007", obs_stall); end
        if (obs_done !== 16'h0008) begin miscompares++; $display("FAIL mis_done got %h exp 0008", obs_done); end
        if (obs_err !== 16'h0008) begin miscompares++; $display("FAIL mis_err got %h exp 0008", obs_err); end
        if (obs_rdata !== 32'h0) begin miscompares++; $display("FAIL mis_rdata got %h exp 0", obs_rdata); end
        run_access(0, 1'b1, 1'b0, 32'h10, 32'h0);
        vectors += 2;
        if (obs_err !== 16'h0000) begin miscompares++; $display("FAIL mis_reread_err got %h exp 0000", obs_err); end
        if (obs_rdata !== 32'hDEAD_BEEF) begin miscompares++; $display("FAIL mis_reread got %h exp deadbeef", obs_rdata); end
    endtask

    task automatic test_both_ops;
        run_access(0, 1'b1, 1'b1, 32'h10, 32'h0);
        vectors += 3;
        if (obs_done !== 16'h0008) begin miscompares++; $display("FAIL both_done got %h exp 0008", obs_done); end
        if (obs_err !== 16'h0008) begin miscompares++; $display("FAIL both_err got %h exp 0008", obs_err); end
        if (obs_rdata !== 32'h0) begin miscompares++; $display("FAIL both_rdata got %h exp 0", obs_rdata); end
        run_access(0, 1'b1, 1'b0, 32'h10, 32'h0);
        vectors += 1;
        if (obs_rdata !== 32'hDEAD_BEEF) begin miscompares++; $display("FAIL both_reread got %h exp deadbeef", obs_rdata); end
    endtask

    task automatic test_reset_mid;
        run_access(0, 1'b0, 1'b1, 32'h20, 32'hA5A5_5A5A);
        run_access(0, 1'b1, 1'b0, 32'h10, 32'h0);
        vectors += 1;
        if (obs_rdata !== 32'hDEAD_BEEF) begin miscompares++; $display("FAIL rm_pre got %h exp deadbeef", obs_rdata); end
        @(posedge clk); #1;
        set_req(0, 1'b0, 1'b1, 32'h20, 32'hCAFE_F00D);
        @(posedge clk); #1;
        vectors += 1;
        if (if0.stall !== 1'b1) begin miscompares++; $display("FAIL rm_wait_stall got %b exp 1", if0.stall); end
        rst = 1'b0;
        #1;
        vectors += 4;
        if (if0.stall !== 1'b0) begin miscompares++; $display("FAIL rm_stall got %b exp 0", if0.stall); end
        if (if0.done !== 1'b0) begin miscompares++; $display("FAIL rm_done got %b exp 0", if0.done); end
        if (if0.err !== 1'b0) begin miscompares++; $display("FAIL rm_err got %b exp 0", if0.err); end
        if (if0.read_data !== 32'h0) begin miscompares++; $display("FAIL rm_rdata got %h exp 0", if0.read_data); end
        set_req(0, 1'b0, 1'b0, 32'h0, 32'h0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        run_access(0, 1'b1, 1'b0, 32'h20, 32'h0);
        vectors += 2;
        if (obs_done !== 16'h0008) begin miscompares++; $display("FAIL rm_post_done got %h exp 0008", obs_done); end
        if (obs_rdata !== 32'hA5A5_5A5A) begin miscompares++; $display("FAIL rm_post_data got %h exp a5a55a5a", obs_rdata); end
    endtask

    task automatic test_zero_wait;
        run_access(1, 1'b0, 1'b1, 32'h8, 32'h1357_2468);
        vectors += 2;
        if (obs_stall !== 16'h0001) begin miscompares++; $display("FAIL zw_wr_stall got %h exp 0001", obs_stall); end
        if (obs_done !== 16'h0002) begin miscompares++; $display("FAIL zw_wr_done got %h exp 0002", obs_done); end
        run_access(1, 1'b1, 1'b0, 32'h8, 32'h0);
        vectors += 4;
        if (obs_stall !== 16'h0001) begin miscompares++; $display("FAIL zw_rd_stall got %h exp 0001", obs_stall); end
        if (obs_done !== 16'h0002) begin miscompares++; $display("FAIL zw_rd_done got %h exp 0002", obs_done); end
        if (obs_err !== 16'h0000) begin miscompares++; $display("FAIL zw_rd_err got %h exp 0000", obs_err); end
        if (obs_rdata !== 32'h1357_2468) begin miscompares++; $display("FAIL zw_rd_data got %h exp 13572468", obs_rdata); end
        run_access(1, 1'b0, 1'b1, 32'hFFC, 32'h0F0F_0F0F);
        run_access(1, 1'b1, 1'b0, 32'hFFC, 32'h0);
        vectors += 2;
        if (obs_err !== 16'h0000) begin miscompares++; $display("FAIL zw_top_err got %h exp 0000", obs_err); end
        if (obs_rdata !== 32'h0F0F_0F0F) begin miscompares++; $display("FAIL zw_top_data got %h exp 0f0f0f0f", obs_rdata); end
        run_access(1, 1'b1, 1'b0, 32'h1000, 32'h0);
        vectors += 3;
        if (obs_done !== 16'h0002) begin miscompares++; $display("FAIL zw_oor_done got %h exp 0002", obs_done); end
        if (obs_err !== 16'h0002) begin miscompares++; $display("FAIL zw_oor_err got %h exp 0002", obs_err); end
        if (obs_rdata !== 32'h0) begin miscompares++; $display("FAIL zw_oor_data got %h exp 0", obs_rdata); end
    endtask

    task automatic test_back_to_back;
        logic [31:0] rd3;
        logic [31:0] rd7;
        run_access(0, 1'b0, 1'b1, 32'h14, 32'h0BAD_F00D);
        obs_stall = '0; obs_done = '0; obs_err = '0;
        rd3 = 32'h0; rd7 = 32'h0;
        @(posedge clk); #1;
        set_req(0, 1'b1, 1'b0, 32'h10, 32'h0);
        for (int k = 0; k <= 7; k++) begin
            if (k > 0) @(posedge clk);
            if (k == 4) begin
                #1;
                set_req(0, 1'b1, 1'b0, 32'h14, 32'h0);
            end
            @(negedge clk);
            sample(0, k);
            if (k == 3) rd3 = if0.read_data;
            if (k == 7) rd7 = if0.read_data;
        end
        @(posedge clk); #1;
        set_req(0, 1'b0, 1'b0, 32'h0, 32'h0);
        @(negedge clk);
        sample(0, 8);
        vectors += 5;
        if (obs_stall !== 16'h0077) begin miscompares++; $display("FAIL b2b_stall got %h exp 0077", obs_stall); end
        if (obs_done !== 16'h0088) begin miscompares++; $display("FAIL b2b_done got %h exp 0088", obs_done); end
        if (obs_err !== 16'h0000) begin miscompares++; $display("FAIL b2b_err got %h exp 0000", obs_err); end
        if (rd3 !== 32'hDEAD_BEEF) begin miscompares++; $display("FAIL b2b_first got %h exp deadbeef", rd3); end
        if (rd7 !== 32'h0BAD_F00D) begin miscompares++; $display("FAIL b2b_second got %h exp 0badf00d", rd7); end
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_misaligned();
        test_both_ops();
        test_reset_mid();
        test_zero_wait();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
